cache_tcam_arbiter: RTL and testbench

CACHE_TCAM_ARBITER -- requirements
Module: cache_tcam_arbiter

---
 rtl/cache_tcam_arbiter.sv | 166 ++++++++++++++++
 tb/tb_cache_tcam_arbiter.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_tcam_arbiter.sv
// Arbitrates two lookup requesters and a config write port onto a single-operation TCAM.
// Optional hit/miss counters are enabled with `define CACHE_TCAM_ARB_STATS_EN.
module cache_tcam_arbiter #(
    parameter int KEY_WIDTH       = 32,
    parameter int TCAM_MATCH_ADDR = 5,
    parameter int LOOKUP_LAT      = 2,
    parameter int WR_STARVE_MAX   = 4
) (
    input  logic                       axis_clk,
    input  logic                       aresetn,
    input  logic [1:0]                 lk_req,
    input  logic [2*KEY_WIDTH-1:0]     lk_key,
    output logic [1:0]                 lk_gnt,
    output logic                       rsp_valid,
    output logic                       rsp_id,
    output logic                       rsp_match,
    output logic [TCAM_MATCH_ADDR-1:0] rsp_addr,
    input  logic                       cfg_wr_valid,
    output logic                       cfg_wr_ready,
    input  logic [TCAM_MATCH_ADDR-1:0] cfg_wr_addr,
    input  logic [KEY_WIDTH-1:0]       cfg_wr_key,
    output logic [KEY_WIDTH-1:0]       tcam_cmp_din,
    output logic                       tcam_we,
    output logic [TCAM_MATCH_ADDR-1:0] tcam_wr_addr,
    output logic [KEY_WIDTH-1:0]       tcam_din,
    input  logic                       tcam_busy,
    input  logic                       tcam_match,
    input  logic [TCAM_MATCH_ADDR-1:0] tcam_match_addr
`ifdef CACHE_TCAM_ARB_STATS_EN
    ,
    output logic [31:0]                stat_hit_cnt,
    output logic [31:0]                stat_miss_cnt
`endif
);

    typedef enum logic [2:0] {IDLE, CMP, WAIT, RESP, WR, WR_WAIT} state_t;

    localparam logic [3:0] STARVE_MAX = 4'(WR_STARVE_MAX);
    localparam logic [2:0] WAIT_LAST  = 3'(LOOKUP_LAT - 1);

    state_t               state;
    logic [3:0]           starve_cnt;
    logic                 last_gnt;
    logic                 cur_id;
    logic [2:0]           wait_cnt;

    logic                 arb_ok;
    logic                 any_req;
    logic                 wr_sel;
    logic                 lk_sel;
    logic                 sel_id;
    logic [KEY_WIDTH-1:0] sel_key;

    // Arbitration is held off while the response strobe is out so grants never overlap it.
    assign arb_ok  = (state == IDLE) && !tcam_busy && !rsp_valid;
    assign any_req = |lk_req;
    assign wr_sel  = arb_ok && cfg_wr_valid && !(any_req && (starve_cnt == STARVE_MAX));
    assign lk_sel  = arb_ok && any_req && !wr_sel;
    assign sel_id  = (lk_req == 2'b11) ? !last_gnt : lk_req[1];
    assign sel_key = sel_id ? lk_key[2*KEY_WIDTH-1:KEY_WIDTH] : lk_key[KEY_WIDTH-1:0];

    assign cfg_wr_ready = wr_sel;

    always_comb begin
        lk_gnt = 2'b00;
        if (lk_sel) begin
            lk_gnt[sel_id] = 1'b1;
        end
    end

    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            state        <= IDLE;
            rsp_valid    <= 1'b0;
            rsp_id       <= 1'b0;
            rsp_match    <= 1'b0;
            rsp_addr     <= '0;
            tcam_we      <= 1'b0;
            tcam_wr_addr <= '0;
            tcam_din     <= '0;
            tcam_cmp_din <= '1;
            starve_cnt   <= '0;
            last_gnt     <= 1'b1;
            cur_id       <= 1'b0;
            wait_cnt     <= '0;
        end else begin
            rsp_valid    <= 1'b0;
            tcam_we      <= wr_sel;
            // The compare register carries the key only for the single CMP cycle.
            tcam_cmp_din <= lk_sel ? sel_key : '1;
            if (wr_sel) begin
                tcam_wr_addr <= cfg_wr_addr;
                tcam_din     <= cfg_wr_key;
            end
            if (lk_sel) begin
                last_gnt <= sel_id;
                cur_id   <= sel_id;
            end
            if (lk_sel || !any_req) begin
                starve_cnt <= '0;
            end else if (wr_sel && (starve_cnt != STARVE_MAX)) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
            case (state)
                IDLE: begin
                    if (lk_sel) begin
                        state <= CMP;
                    end else if (wr_sel) begin
                        state <= WR;
                    end
                end
                CMP: begin
                    wait_cnt <= 3'd1;
                    if (LOOKUP_LAT == 1) begin
                        state <= RESP;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        state <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 3'd1;
                    end
                end
                RESP: begin
                    rsp_valid <= 1'b1;
                    rsp_id    <= cur_id;
                    rsp_match <= tcam_match;
                    rsp_addr  <= tcam_match ? tcam_match_addr : '0;
                    state     <= IDLE;
                end
                WR: begin
                    wait_cnt <= '0;
                    state    <= WR_WAIT;
                end
                WR_WAIT: begin
                    // Two-cycle floor, then wait for the TCAM to finish the write.
                    if ((wait_cnt != 3'd0) && !tcam_busy) begin
                        state <= IDLE;
                    end else begin
                        wait_cnt <= 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CACHE_TCAM_ARB_STATS_EN
    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            stat_hit_cnt  <= '0;
            stat_miss_cnt <= '0;
        end else if (rsp_valid) begin
            if (rsp_match) begin
                stat_hit_cnt <= stat_hit_cnt + 32'd1;
            end else begin
                stat_miss_cnt <= stat_miss_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cache_tcam_arbiter.sv
// Directed and randomized bench for cache_tcam_arbiter with a behavioural TCAM and
// a transaction-level reference model of grants, writes and responses.
module tb_cache_tcam_arbiter;

    localparam int KW   = 32;
    localparam int AW   = 5;
    localparam int LAT  = 2;
    localparam int SMAX = 4;

    logic          axis_clk = 1'b0;
    logic          aresetn;
    logic [1:0]    lk_req;
    logic [2*KW-1:0] lk_key;
    logic [1:0]    lk_gnt;
    logic          rsp_valid;
    logic          rsp_id;
    logic          rsp_match;
    logic [AW-1:0] rsp_addr;
    logic          cfg_wr_valid;
    logic          cfg_wr_ready;
    logic [AW-1:0] cfg_wr_addr;
    logic [KW-1:0] cfg_wr_key;
    logic [KW-1:0] tcam_cmp_din;
    logic          tcam_we;
    logic [AW-1:0] tcam_wr_addr;
    logic [KW-1:0] tcam_din;
    logic          tcam_busy;
    logic          tcam_match;
    logic [AW-1:0] tcam_match_addr;
`ifdef CACHE_TCAM_ARB_STATS_EN
    logic [31:0]   stat_hit_cnt;
    logic [31:0]   stat_miss_cnt;
`endif

    always #5 axis_clk = ~axis_clk;

    cache_tcam_arbiter #(
        .KEY_WIDTH(KW), .TCAM_MATCH_ADDR(AW), .LOOKUP_LAT(LAT), .WR_STARVE_MAX(SMAX)
    ) dut (
        .axis_clk(axis_clk), .aresetn(aresetn),
        .lk_req(lk_req), .lk_key(lk_key), .lk_gnt(lk_gnt),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_match(rsp_match), .rsp_addr(rsp_addr),
        .cfg_wr_valid(cfg_wr_valid), .cfg_wr_ready(cfg_wr_ready),
        .cfg_wr_addr(cfg_wr_addr), .cfg_wr_key(cfg_wr_key),
        .tcam_cmp_din(tcam_cmp_din), .tcam_we(tcam_we),
        .tcam_wr_addr(tcam_wr_addr), .tcam_din(tcam_din),
        .tcam_busy(tcam_busy), .tcam_match(tcam_match), .tcam_match_addr(tcam_match_addr)
`ifdef CACHE_TCAM_ARB_STATS_EN
        , .stat_hit_cnt(stat_hit_cnt), .stat_miss_cnt(stat_miss_cnt)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Behavioural TCAM: exact match, lowest address wins, result LAT cycles after compare.
    logic [KW-1:0] hist [LAT];
    logic [KW-1:0] tk [32];
    bit            tv [32];

    always @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < LAT; i++) hist[i] <= '1;
        end else begin
            hist[0] <= tcam_cmp_din;
            for (int i = 1; i < LAT; i++) hist[i] <= hist[i-1];
        end
    end

    always @(posedge axis_clk) begin
        if (tcam_we) begin
            tk[tcam_wr_addr] <= tcam_din;
            tv[tcam_wr_addr] <= 1'b1;
        end
    end

    always_comb begin
        tcam_match      = 1'b0;
        tcam_match_addr = '0;
        for (int i = 31; i >= 0; i--) begin
            if (tv[i] && (tk[i] == hist[LAT-1])) begin
                tcam_match      = 1'b1;
                tcam_match_addr = 5'(i);
            end
        end
    end

    // Reference model state, driven from accepted transactions only.
    typedef struct { int due; bit id; bit m; logic [AW-1:0] a; } rsp_t;
    rsp_t          q[$];
    logic [KW-1:0] rk [32];
    bit            rv [32];
    int            cyc = 0;
    bit            last_m = 1'b1;
    int            starve_m = 0;
    int            cmp_due = -1, we_due = -1, block_until = 0;
    logic [KW-1:0] cmp_key, we_key;
    logic [AW-1:0] we_addr;
    bit            h_id, h_m;
    logic [AW-1:0] h_a;
    int            hits = 0, misses = 0;

    function automatic void ref_lookup(input logic [KW-1:0] k, output bit m, output logic [AW-1:0] a);
        m = 1'b0;
        a = '0;
        for (int i = 0; i < 32; i++) begin
            if (rv[i] && rk[i] == k) begin
                m = 1'b1;
                a = 5'(i);
                break;
            end
        end
    endfunction

    always @(posedge axis_clk) cyc <= cyc + 1;

    bit            acc_m;
    bit            id_m;
    bit            exp_v;
    int            excl;
    rsp_t          e;
    logic [KW-1:0] key_m;

    always @(negedge axis_clk) begin
        if (!aresetn) begin
            check("rst_gnt", lk_gnt, 0);
            check("rst_rsp_valid", rsp_valid, 0);
            check("rst_rsp_fields", {rsp_id, rsp_match, rsp_addr}, 0);
            check("rst_we", tcam_we, 0);
            check("rst_wr_port", {tcam_wr_addr, tcam_din}, 0);
            check("rst_cmp_din", tcam_cmp_din, 32'hFFFF_FFFF);
            check("rst_ready", cfg_wr_ready, 0);
            q.delete();
            last_m = 1'b1; starve_m = 0; cmp_due = -1; we_due = -1; block_until = 0;
            h_id = 0; h_m = 0; h_a = '0; hits = 0; misses = 0;
        end else begin
            acc_m = cfg_wr_valid && cfg_wr_ready;
            while (q.size() > 0 && q[0].due < cyc) void'(q.pop_front());
            exp_v = (q.size() > 0) && (q[0].due == cyc);
            check("rsp_valid", rsp_valid, exp_v);
            if (exp_v) begin
                e = q.pop_front();
                h_id = e.id; h_m = e.m; h_a = e.a;
                if (e.m) hits++; else misses++;
            end
            check("rsp_id", rsp_id, h_id);
            check("rsp_match", rsp_match, h_m);
            check("rsp_addr", rsp_addr, h_a);
            check("cmp_din", tcam_cmp_din, (cyc == cmp_due) ? cmp_key : 32'hFFFF_FFFF);
            check("tcam_we", tcam_we, cyc == we_due);
            if (cyc == we_due) check("tcam_wr_data", {tcam_wr_addr, tcam_din}, {we_addr, we_key});
            excl = int'(lk_gnt != 0) + int'(tcam_we) + int'(rsp_valid);
            check("exclusive", excl <= 1, 1);
            if (tcam_busy) check("busy_quiet", {lk_gnt, cfg_wr_ready}, 0);
            if (lk_gnt != 0 || acc_m) check("arb_spacing", cyc >= block_until, 1);
            if (lk_gnt != 0) begin
                check("gnt_onehot", $onehot(lk_gnt), 1);
                id_m = lk_gnt[1];
                check("gnt_req", lk_req[id_m], 1);
                if (lk_req == 2'b11) check("round_robin", id_m, !last_m);
                check("wr_priority", cfg_wr_valid && (starve_m != SMAX), 0);
                key_m = id_m ? lk_key[2*KW-1:KW] : lk_key[KW-1:0];
                e.due = cyc + LAT + 2;
                e.id  = id_m;
                ref_lookup(key_m, e.m, e.a);
                q.push_back(e);
                cmp_due = cyc + 1; cmp_key = key_m;
                last_m = id_m;
                block_until = cyc + LAT + 3;
            end
            if (acc_m) begin
                check("starve_limit", (starve_m == SMAX) && (lk_req != 0), 0);
                rk[cfg_wr_addr] = cfg_wr_key;
                rv[cfg_wr_addr] = 1'b1;
                we_due = cyc + 1; we_addr = cfg_wr_addr; we_key = cfg_wr_key;
                block_until = cyc + 4;
            end
            if (lk_gnt != 0 || lk_req == 0) starve_m = 0;
            else if (acc_m && starve_m < SMAX) starve_m++;
        end
    end

    task automatic step();
        @(posedge axis_clk);
        #1;
    endtask

    task automatic apply_stimulus_reset();
        aresetn = 1'b0; lk_req = 2'b00; cfg_wr_valid = 1'b0; tcam_busy = 1'b0;
        repeat (2) step();
        aresetn = 1'b1;
        step();
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [KW-1:0] k);
        bit done = 0;
        cfg_wr_addr = a; cfg_wr_key = k; cfg_wr_valid = 1'b1;
        for (int n = 0; n < 100 && !done; n++) begin
            @(negedge axis_clk);
            if (cfg_wr_ready) done = 1;
            step();
        end
        cfg_wr_valid = 1'b0;
        check("wr_timeout", done, 1);
    endtask

    task automatic wait_gnt(input int id, output int gcyc);
        bit ok = 0;
        gcyc = 0;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge axis_clk);
            if (lk_gnt[id]) begin ok = 1; gcyc = cyc; end
            step();
        end
        check("gnt_timeout", ok, 1);
    endtask

    task automatic wait_rsp(output int rcyc, output bit rid, output bit rm, output logic [AW-1:0] ra);
        bit ok = 0;
        rcyc = 0; rid = 0; rm = 0; ra = '0;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge axis_clk);
            if (rsp_valid) begin ok = 1; rcyc = cyc; rid = rsp_id; rm = rsp_match; ra = rsp_addr; end
            step();
        end
        check("rsp_timeout", ok, 1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    logic [KW-1:0] pool [8];
    int            g, r, nev, nw, ng, nr;
    bit            rid, rm, acc;
    logic [AW-1:0] ra;
    logic [1:0]    g2;
    bit            ev [11];
    bit            gid [4];
    int            gcy [4];

    initial begin
        for (int i = 0; i < 8; i++) pool[i] = 32'h1000_0000 + 32'(i) * 32'h0101;
        aresetn = 1'b0; lk_req = 2'b00; lk_key = '0; cfg_wr_valid = 1'b0;
        cfg_wr_addr = '0; cfg_wr_key = '0; tcam_busy = 1'b0;
        apply_stimulus_reset();

        // Write entry 3, then a hitting lookup from requester 0.
        do_write(5'd3, 32'h0A00_0001);
        lk_key[KW-1:0] = 32'h0A00_0001; lk_req = 2'b01;
        wait_gnt(0, g);
        lk_req = 2'b00;
        wait_rsp(r, rid, rm, ra);
        check("d_hit_latency", r - g, LAT + 2);
        check("d_hit_id", rid, 0);
        check("d_hit_match", rm, 1);
        check("d_hit_addr", ra, 3);

        // Reset two cycles into a lookup aborts it.
        lk_req = 2'b01;
        wait_gnt(0, g);
        step();
        aresetn = 1'b0; lk_req = 2'b00;
        @(negedge axis_clk);
        check("d_abort_rst_gnt", lk_gnt, 0);
        check("d_abort_rst_cmp", tcam_cmp_din, 32'hFFFF_FFFF);
        step(); step();
        aresetn = 1'b1;
        for (int n = 0; n < 10; n++) begin
            @(negedge axis_clk);
            check("d_abort_no_rsp", rsp_valid, 0);
            step();
        end

        // Both requesters held with missing keys alternate starting at requester 0.
        lk_key = {32'hBEEF_0001, 32'hDEAD_0000}; lk_req = 2'b11;
        ng = 0; nr = 0;
        for (int n = 0; n < 200 && (ng < 4 || nr < 4); n++) begin
            @(negedge axis_clk);
            if (lk_gnt != 0 && ng < 4) begin gid[ng] = lk_gnt[1]; gcy[ng] = cyc; ng++; end
            if (rsp_valid) begin
                check("d_miss_match", rsp_match, 0);
                check("d_miss_addr", rsp_addr, 0);
                nr++;
            end
            step();
            if (ng == 4) lk_req = 2'b00;
        end
        check("d_rr_count", ng, 4);
        for (int i = 0; i < 4; i++) check("d_rr_order", gid[i], i % 2);
        for (int i = 1; i < 4; i++) check("d_rr_period", gcy[i] - gcy[i-1], LAT + 3);

        // Ten queued writes against a waiting lookup: four writes, the lookup, then the rest.
        lk_key[2*KW-1:KW] = 32'h0A00_0001; lk_req = 2'b10;
        cfg_wr_addr = 5'd10; cfg_wr_key = 32'h2000_0000; cfg_wr_valid = 1'b1;
        nev = 0; nw = 0;
        for (int n = 0; n < 300 && nev < 11; n++) begin
            @(negedge axis_clk);
            g2 = lk_gnt; acc = cfg_wr_valid && cfg_wr_ready;
            if (g2 != 0) begin ev[nev] = 1'b1; nev++; end
            if (acc) begin ev[nev] = 1'b0; nev++; nw++; end
            step();
            if (g2 != 0) lk_req = 2'b00;
            if (acc) begin
                if (nw == 10) cfg_wr_valid = 1'b0;
                else begin cfg_wr_addr = 5'(10 + nw); cfg_wr_key = 32'h2000_0000 + 32'(nw); end
            end
        end
        check("d_starve_events", nev, 11);
        for (int i = 0; i < 11; i++) check("d_starve_order", ev[i], i == 4);
        repeat (10) step();

        // TCAM busy blocks every grant and write until it falls.
        tcam_busy = 1'b1; lk_key[KW-1:0] = 32'hDEAD_0000; lk_req = 2'b01;
        cfg_wr_addr = 5'd20; cfg_wr_key = 32'h3000_0000; cfg_wr_valid = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge axis_clk);
            check("d_busy_gnt", lk_gnt, 0);
            check("d_busy_ready", cfg_wr_ready, 0);
            check("d_busy_we", tcam_we, 0);
            step();
        end
        tcam_busy = 1'b0; cfg_wr_valid = 1'b0;
        @(negedge axis_clk);
        check("d_first_gnt_after_busy", lk_gnt, 2'b01);
        step();
        lk_req = 2'b00;
        repeat (10) step();

        // Randomized traffic against the reference model.
        for (int c = 0; c < 1500; c++) begin
            @(negedge axis_clk);
            g2 = lk_gnt; acc = cfg_wr_valid && cfg_wr_ready;
            step();
            for (int i = 0; i < 2; i++) begin
                if (g2[i]) lk_req[i] = 1'b0;
                else if (!lk_req[i] && $urandom_range(0, 3) == 0) begin
                    lk_req[i] = 1'b1;
                    if ($urandom_range(0, 3) == 0) lk_key[i*KW +: KW] = $urandom() & 32'hFFFF_FFFE;
                    else lk_key[i*KW +: KW] = pool[$urandom_range(0, 7)];
                end else if (lk_req[i] && $urandom_range(0, 31) == 0) lk_req[i] = 1'b0;
            end
            if (acc) cfg_wr_valid = 1'b0;
            else if (!cfg_wr_valid && $urandom_range(0, 3) == 0) begin
                cfg_wr_valid = 1'b1;
                cfg_wr_addr  = 5'($urandom_range(0, 31));
                cfg_wr_key   = pool[$urandom_range(0, 7)];
            end
            tcam_busy = ($urandom_range(0, 9) == 0);
        end

        lk_req = 2'b00; cfg_wr_valid = 1'b0; tcam_busy = 1'b0;
        for (int n = 0; n < 50 && q.size() > 0; n++) step();
        repeat (3) step();
        check("drain_empty", q.size(), 0);
`ifdef CACHE_TCAM_ARB_STATS_EN
        check("stat_hits", stat_hit_cnt, hits);
        check("stat_misses", stat_miss_cnt, misses);
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
